// File: rtl/regfile_decoded_pkg.sv
// Shared types, sizes and small decoder helpers for the decoded register file.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
package regfile_decoded_pkg;

    localparam int REGFILE_DATA_WIDTH = 32;
    localparam int REGFILE_ADDR_WIDTH = 5;
    localparam int REGFILE_NUM_REGS   = 32;

    typedef logic [REGFILE_DATA_WIDTH-1:0] reg_word_t;
    typedef logic [REGFILE_ADDR_WIDTH-1:0] reg_idx_t;

    localparam reg_idx_t ZERO_REG = '0;

    // Enabled 2-to-4 decoder: all zeros when disabled.
    function automatic logic [3:0] dec2to4(input logic en, input logic [1:0] a);
        dec2to4 = en ? (4'b0001 << a) : 4'b0000;
    endfunction

    // Enabled 3-to-8 decoder: all zeros when disabled.
    function automatic logic [7:0] dec3to8(input logic en, input logic [2:0] a);
        dec3to8 = en ? (8'b0000_0001 << a) : 8'b0000_0000;
    endfunction

endpackage

// File: rtl/regfile_decoded_if.sv
// Write/read port bundle of the decoded register file.
// Latency: n/a (wiring only).
// Backpressure: none; writes and reads are always accepted.
interface regfile_decoded_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  ctrl_writeEnable;
    logic [ADDR_WIDTH-1:0] ctrl_writeReg;
    logic [ADDR_WIDTH-1:0] ctrl_readRegA;
    logic [ADDR_WIDTH-1:0] ctrl_readRegB;
    logic [DATA_WIDTH-1:0] data_writeReg;
    logic [DATA_WIDTH-1:0] data_readRegA;
    logic [DATA_WIDTH-1:0] data_readRegB;

    // Datapath side that issues writes and read indices.
    modport master (
        output ctrl_writeEnable, ctrl_writeReg, ctrl_readRegA, ctrl_readRegB, data_writeReg,
        input  data_readRegA, data_readRegB
    );

    // Register file side.
    modport slave (
        input  ctrl_writeEnable, ctrl_writeReg, ctrl_readRegA, ctrl_readRegB, data_writeReg,
        output data_readRegA, data_readRegB
    );
endinterface

// File: rtl/regfile_decoded_decoder5to32.sv
// One-hot write select: 2-to-4 steers four enabled 3-to-8 banks; output already gated by en.
// Latency: combinational.
// Backpressure: none.
module regfile_decoded_decoder5to32
    import regfile_decoded_pkg::*;
(
    input  logic                        en,
    input  reg_idx_t                    addr,
    output logic [REGFILE_NUM_REGS-1:0] onehot
);

    logic [3:0] bank_en;

    // Upper two index bits pick a bank of eight, lower three pick the register in it.
    always_comb begin
        bank_en = dec2to4(en, addr[4:3]);
        onehot  = '0;
        for (int b = 0; b < 4; b++) begin
            onehot[b*8 +: 8] = dec3to8(bank_en[b], addr[2:0]);
        end
    end

endmodule

// File: rtl/regfile_decoded_reg_word.sv
// One register word with load enable and asynchronous active-low clear.
// Latency: 1 cycle from load_en to q_out.
// Backpressure: none.
module regfile_decoded_reg_word
    import regfile_decoded_pkg::*;
#(
    parameter int DATA_WIDTH = REGFILE_DATA_WIDTH
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  load_en,
    input  logic [DATA_WIDTH-1:0] d_in,
    output logic [DATA_WIDTH-1:0] q_out
);

    logic [DATA_WIDTH-1:0] data_d;
    logic [DATA_WIDTH-1:0] data_q;

    // Hold unless this word is the selected write target.
    always_comb begin
        data_d = data_q;
        if (load_en) begin
            data_d = d_in;
        end
    end

    // Word storage; reset clears regardless of clock.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_out = data_q;

endmodule

// File: rtl/regfile_decoded.sv
// 32x32 register file, r0 hardwired to zero, one decoded write port, two combinational reads.
// Latency: write visible 1 cycle after the edge; reads 0 cycles (REGFILE_BYPASS_EN adds write-through).
// Backpressure: none; every write and read is accepted every cycle.
module regfile_decoded
    import regfile_decoded_pkg::*;
#(
    parameter int DATA_WIDTH = REGFILE_DATA_WIDTH,
    parameter int ADDR_WIDTH = REGFILE_ADDR_WIDTH
) (
    input  logic              clock,
    input  logic              ctrl_reset_n,
    regfile_decoded_if.slave  rf
);

    localparam int NUM_REGS = 1 << ADDR_WIDTH;

    logic [NUM_REGS-1:0]   load_sel;
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [DATA_WIDTH-1:0] rd_a;
    logic [DATA_WIDTH-1:0] rd_b;
    logic                  unused_sel0;

    regfile_decoded_decoder5to32 u_dec (
        .en     (rf.ctrl_writeEnable),
        .addr   (rf.ctrl_writeReg),
        .onehot (load_sel)
    );

    // Register 0 has no storage, so its select line goes nowhere.
    assign unused_sel0 = load_sel[0];
    assign regs[0]     = '0;

    for (genvar i = 1; i < NUM_REGS; i++) begin : g_word
        regfile_decoded_reg_word #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_word (
            .clock   (clock),
            .rst_n   (ctrl_reset_n),
            .load_en (load_sel[i]),
            .d_in    (rf.data_writeReg),
            .q_out   (regs[i])
        );
    end

    // Read muxes; the optional forward lets a same-cycle write appear before the edge.
    always_comb begin
        rd_a = regs[rf.ctrl_readRegA];
        rd_b = regs[rf.ctrl_readRegB];
`ifdef REGFILE_BYPASS_EN
        if (ctrl_reset_n && rf.ctrl_writeEnable && (rf.ctrl_writeReg != ZERO_REG)) begin
            if (rf.ctrl_readRegA == rf.ctrl_writeReg) begin
                rd_a = rf.data_writeReg;
            end
            if (rf.ctrl_readRegB == rf.ctrl_writeReg) begin
                rd_b = rf.data_writeReg;
            end
        end
`endif
    end

    assign rf.data_readRegA = rd_a;
    assign rf.data_readRegB = rd_b;

endmodule

// File: tb/tb_regfile_decoded.sv
// Self-checking bench for regfile_decoded with a queue-based scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_regfile_decoded;

    logic        clock;
    logic        rst_n;
    logic [31:0] model [32];
    logic [31:0] q_a [$];
    logic [31:0] q_b [$];
    int          total;
    int          bad;

    regfile_decoded_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) rf_if ();

    regfile_decoded dut (
        .clock        (clock),
        .ctrl_reset_n (rst_n),
        .rf           (rf_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive one write and retire it into the model after the edge.
    task automatic write_reg(input logic [4:0] idx, input logic [31:0] val);
        @(negedge clock);
        rf_if.ctrl_writeEnable = 1'b1;
        rf_if.ctrl_writeReg    = idx;
        rf_if.data_writeReg    = val;
        @(posedge clock);
        #1;
        rf_if.ctrl_writeEnable = 1'b0;
        if (idx != 5'd0 && rst_n) model[idx] = val;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endtask

    task automatic test_reset();
        logic [31:0] got_a, got_b, exp_a, exp_b;
        for (int i = 0; i < 8; i++) write_reg(5'($urandom_range(1, 31)), $urandom);
        @(negedge clock);
        rst_n = 1'b0;
        clear_model();
        repeat (3) @(posedge clock);
        #1;
        for (int i = 0; i < 32; i++) begin
            rf_if.ctrl_readRegA = 5'(i);
            rf_if.ctrl_readRegB = 5'(31 - i);
            q_a.push_back(model[i]);
            q_b.push_back(model[31 - i]);
            #1;
            got_a = rf_if.data_readRegA;
            got_b = rf_if.data_readRegB;
            exp_a = q_a.pop_front();
            exp_b = q_b.pop_front();
            total++;
            if (got_a !== exp_a || got_b !== exp_b) begin
                bad++;
                $display("FAIL reset_hold idx=%0d got A=%h B=%h want A=%h B=%h", i, got_a, got_b, exp_a, exp_b);
            end
        end
        @(negedge clock);
        rst_n = 1'b1;
    endtask

    task automatic test_write_readback();
        logic [31:0] got_a, got_b, exp_a, exp_b;
        write_reg(5'd7, 32'hDEADBEEF);
        write_reg(5'd31, 32'h12345678);
        @(negedge clock);
        rf_if.ctrl_readRegA = 5'd7;
        rf_if.ctrl_readRegB = 5'd31;
        q_a.push_back(32'hDEADBEEF);
        q_b.push_back(32'h12345678);
        #1;
        got_a = rf_if.data_readRegA;
        got_b = rf_if.data_readRegB;
        exp_a = q_a.pop_front();
        exp_b = q_b.pop_front();
        total++;
        if (got_a !== exp_a || got_b !== exp_b) begin
            bad++;
            $display("FAIL readback got A=%h B=%h want A=%h B=%h", got_a, got_b, exp_a, exp_b);
        end
        for (int i = 0; i < 32; i++) begin
            if (i == 7 || i == 31) continue;
            rf_if.ctrl_readRegA = 5'(i);
            rf_if.ctrl_readRegB = 5'(i);
            q_a.push_back(32'h0);
            #1;
            got_a = rf_if.data_readRegA;
            got_b = rf_if.data_readRegB;
            exp_a = q_a.pop_front();
            total++;
            if (got_a !== exp_a || got_b !== exp_a) begin
                bad++;
                $display("FAIL others_zero idx=%0d got A=%h B=%h want %h", i, got_a, got_b, exp_a);
            end
        end
    endtask

    task automatic test_zero_reg();
        logic [31:0] got_a, got_b, exp_a;
        write_reg(5'd0, 32'hFFFFFFFF);
        @(negedge clock);
        rf_if.ctrl_readRegA = 5'd0;
        rf_if.ctrl_readRegB = 5'd0;
        q_a.push_back(32'h0);
        #1;
        got_a = rf_if.data_readRegA;
        got_b = rf_if.data_readRegB;
        exp_a = q_a.pop_front();
        total++;
        if (got_a !== exp_a || got_b !== exp_a) begin
            bad++;
            $display("FAIL zero_reg got A=%h B=%h want %h", got_a, got_b, exp_a);
        end
        // A write to r0 in flight must not leak through either.
        rf_if.ctrl_writeEnable = 1'b1;
        rf_if.ctrl_writeReg    = 5'd0;
        rf_if.data_writeReg    = 32'hCAFEF00D;
        q_a.push_back(32'h0);
        #1;
        got_a = rf_if.data_readRegA;
        exp_a = q_a.pop_front();
        total++;
        if (got_a !== exp_a) begin
            bad++;
            $display("FAIL zero_reg_inflight got %h want %h", got_a, exp_a);
        end
        @(posedge clock);
        #1;
        rf_if.ctrl_writeEnable = 1'b0;
    endtask

    task automatic test_onehot();
        logic [31:0] got_a, got_b, exp_a, exp_b;
        for (int i = 1; i < 32; i++) write_reg(5'(i), 32'(i) * 32'h01010101);
        @(negedge clock);
        for (int i = 0; i < 32; i++) begin
            rf_if.ctrl_readRegA = 5'(i);
            rf_if.ctrl_readRegB = 5'(31 - i);
            q_a.push_back(32'(i) * 32'h01010101);
            q_b.push_back(32'(31 - i) * 32'h01010101);
            #1;
            got_a = rf_if.data_readRegA;
            got_b = rf_if.data_readRegB;
            exp_a = q_a.pop_front();
            exp_b = q_b.pop_front();
            total++;
            if (got_a !== exp_a || got_b !== exp_b) begin
                bad++;
                $display("FAIL onehot idx=%0d got A=%h B=%h want A=%h B=%h", i, got_a, got_b, exp_a, exp_b);
            end
        end
    endtask

    task automatic test_same_cycle();
        logic [31:0] got_a, got_b, exp_a;
        write_reg(5'd5, 32'hA);
        @(negedge clock);
        rf_if.ctrl_readRegA    = 5'd5;
        rf_if.ctrl_readRegB    = 5'd5;
        rf_if.ctrl_writeEnable = 1'b1;
        rf_if.ctrl_writeReg    = 5'd5;
        rf_if.data_writeReg    = 32'hB;
`ifdef REGFILE_BYPASS_EN
        q_a.push_back(32'hB);
`else
        q_a.push_back(32'hA);
`endif
        #1;
        got_a = rf_if.data_readRegA;
        got_b = rf_if.data_readRegB;
        exp_a = q_a.pop_front();
        total++;
        if (got_a !== exp_a || got_b !== exp_a) begin
            bad++;
            $display("FAIL same_cycle_before got A=%h B=%h want %h", got_a, got_b, exp_a);
        end
        q_a.push_back(32'hB);
        @(posedge clock);
        #1;
        rf_if.ctrl_writeEnable = 1'b0;
        model[5] = 32'hB;
        #1;
        got_a = rf_if.data_readRegA;
        got_b = rf_if.data_readRegB;
        exp_a = q_a.pop_front();
        total++;
        if (got_a !== exp_a || got_b !== exp_a) begin
            bad++;
            $display("FAIL same_cycle_after got A=%h B=%h want %h", got_a, got_b, exp_a);
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] got_a, exp_a;
        write_reg(5'd3, 32'h77);
        @(negedge clock);
        rf_if.ctrl_readRegA    = 5'd3;
        rf_if.ctrl_readRegB    = 5'd7;
        rf_if.ctrl_writeEnable = 1'b1;
        rf_if.ctrl_writeReg    = 5'd3;
        rf_if.data_writeReg    = 32'h55;
        #2;
        rst_n = 1'b0;
        clear_model();
        q_a.push_back(model[3]);
        #1;
        got_a = rf_if.data_readRegA;
        exp_a = q_a.pop_front();
        total++;
        if (got_a !== exp_a) begin
            bad++;
            $display("FAIL async_reset_immediate got %h want %h", got_a, exp_a);
        end
        q_a.push_back(model[7]);
        #0;
        got_a = rf_if.data_readRegB;
        exp_a = q_a.pop_front();
        total++;
        if (got_a !== exp_a) begin
            bad++;
            $display("FAIL async_reset_other got %h want %h", got_a, exp_a);
        end
        q_a.push_back(32'h0);
        @(posedge clock);
        #1;
        got_a = rf_if.data_readRegA;
        exp_a = q_a.pop_front();
        total++;
        if (got_a !== exp_a) begin
            bad++;
            $display("FAIL async_reset_after_edge got %h want %h", got_a, exp_a);
        end
        rf_if.ctrl_writeEnable = 1'b0;
        @(negedge clock);
        rst_n = 1'b1;
        write_reg(5'd3, 32'h55);
        @(negedge clock);
        q_a.push_back(model[3]);
        #1;
        got_a = rf_if.data_readRegA;
        exp_a = q_a.pop_front();
        total++;
        if (got_a !== exp_a) begin
            bad++;
            $display("FAIL post_reset_write got %h want %h", got_a, exp_a);
        end
    endtask

    initial begin
        logic [31:0] got_a, got_b;
        total = 0;
        bad   = 0;
        clear_model();
        rst_n                  = 1'b0;
        rf_if.ctrl_writeEnable = 1'b0;
        rf_if.ctrl_writeReg    = 5'd0;
        rf_if.ctrl_readRegA    = 5'd9;
        rf_if.ctrl_readRegB    = 5'd31;
        rf_if.data_writeReg    = 32'h0;
        #2;
        got_a = rf_if.data_readRegA;
        got_b = rf_if.data_readRegB;
        total++;
        if (got_a !== 32'h0 || got_b !== 32'h0) begin
            bad++;
            $display("FAIL initial_reset got A=%h B=%h want 0", got_a, got_b);
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        rst_n = 1'b1;

        test_reset();
        test_write_readback();
        test_zero_reg();
        test_onehot();
        test_same_cycle();
        test_async_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_decoded.md
Name: regfile_decoded

Overview:
- Register file that consumes the one-hot write-select produced by the team's 3-to-8/2-to-4 decoder family.
- Holds 2**ADDR_WIDTH general-purpose registers, with one synchronous write port and two combinational read ports.
- Register 0 is hardwired to zero.
- Sits directly downstream of the write-address decoder and feeds the ALU operand path of the processor datapath.

Parameters:
- DATA_WIDTH, 32, width of each register and of every data port.
- ADDR_WIDTH, 5, register index width; NUM_REGS = 2**ADDR_WIDTH = 32.

Ports:
- clock  input  1  single rising-edge clock for all state.
- ctrl_reset_n  input  1  asynchronous, active-low reset; clears every register.
- ctrl_writeEnable  input  1  write strobe, sampled at the rising edge of clock.
- ctrl_writeReg  input  ADDR_WIDTH  destination register index.
- ctrl_readRegA  input  ADDR_WIDTH  read port A index.
- ctrl_readRegB  input  ADDR_WIDTH  read port B index.
- data_writeReg  input  DATA_WIDTH  write data.
- data_readRegA  output  DATA_WIDTH  contents of register ctrl_readRegA.
- data_readRegB  output  DATA_WIDTH  contents of register ctrl_readRegB.

Behaviour:
- Reset:
  - ctrl_reset_n low forces all registers to 0 immediately, with no dependence on clock.
  - Both read outputs therefore read 0 while reset is held.
  - Deassertion takes effect at the next rising edge of clock; no write occurs on the edge where ctrl_reset_n is low.
- Write decode:
  - ctrl_writeReg is decoded to a NUM_REGS-bit one-hot select.
  - Each register's load enable = ctrl_writeEnable AND select[i].
  - At most one register loads per cycle.
- Write timing: on the rising edge of clock with the load enable high, register i takes data_writeReg. The value is visible on the read ports from that edge onward, so write latency is 1 cycle.
- Register 0: never loads and always reads 0. A write to index 0 is silently discarded.
- Reads:
  - Purely combinational mux on ctrl_readRegA/B, with 0-cycle latency.
  - A and B are independent, may be equal, and may equal ctrl_writeReg.
- Same-cycle read/write of one index, bypass not compiled: the read returns the old value until the edge, then the new value.
- Mid-operation reset: reset asserted in the same cycle as a write wins, and the register ends at 0.
- Read indices are never out of range (full decode), so there are no X outputs after reset.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- When defined: a read port whose index equals ctrl_writeReg, while ctrl_writeEnable = 1 and the index is not 0, outputs data_writeReg combinationally in the same cycle (write-through forwarding).
  - Index 0 is never bypassed.
  - Bypass is suppressed while ctrl_reset_n is low.
- When undefined: reads always reflect stored state only.

Decomposition:
- Shared package holds:
  - REGFILE_DATA_WIDTH = 32
  - REGFILE_ADDR_WIDTH = 5
  - REGFILE_NUM_REGS = 32
  - ZERO_REG index = 0
  - typedef reg_word_t (DATA_WIDTH bits)
  - typedef reg_idx_t (ADDR_WIDTH bits)
- Natural sub-modules:
  - decoder5to32: the one-hot write select, built from four enabled 3-to-8 decoders steered by one 2-to-4 decoder.
  - reg_word: one DATA_WIDTH-bit register with load enable and asynchronous active-low clear, instantiated 31 times.

Test Plan:
- Reset hold: ctrl_reset_n=0 for 3 cycles after random writes -> data_readRegA/B = 0x00000000 for every index 0..31.
- Write/readback: write 0xDEADBEEF to r7 and 0x12345678 to r31 -> next cycle readRegA=7 gives 0xDEADBEEF and readRegB=31 gives 0x12345678. All other registers remain 0.
- Zero register: write 0xFFFFFFFF to index 0 -> both ports reading index 0 return 0x00000000.
- One-hot check: write a distinct value (index*0x01010101) to r1..r31 -> sweeping both ports returns exactly each register's value, with no aliasing.
- Same-cycle read/write of r5 (old 0xA, new 0xB), ctrl_writeEnable=1:
  - Without REGFILE_BYPASS_EN, the read in that cycle = 0xA and after the edge = 0xB.
  - With REGFILE_BYPASS_EN, the read = 0xB in the same cycle.
- Asynchronous reset mid-write: assert ctrl_reset_n low between edges while a write of 0x55 to r3 is pending -> r3 reads 0 immediately and is still 0 after the edge.
